div_act_array: RTL and testbench
================================

# div_act_array

Time-multiplexed activation-derivative engine for the backpropagation datapath. Accepts a packed vector of CH fixed-point activations and returns, per lane, the sigmoid derivative a·(1−a) or, when compiled in, the tanh derivative 1−a². A single shared multiplier is iterated over the lanes by a small FSM. The block sits between the forward-pass activation store and the delta (error) computation, behind a valid/ready handshake on both sides.

## Interface
- WIDTH, 32: signed fixed-point word width.
- FRAC, 24: fractional bits; one = 1<<FRAC.
- CH, 4: lane count, ≥1; the lane counter is $clog2(CH) bits, minimum 1.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block can accept a vector.
- in_data  input  CH*WIDTH  activations; lane k at [k*WIDTH +: WIDTH].
- in_mode  input  1  0 = sigmoid derivative, 1 = tanh derivative.
- out_valid  output  1  result vector valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  CH*WIDTH  derivatives, same lane packing as in_data.
- out_sat  output  1  at least one lane saturated in this vector.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture in_data and in_mode, clear the sat accumulator, set idx=0, go to CALC.
  - CALC: in_ready=0 and out_valid=0. Each cycle computes lane idx, writes it to result register lane idx, and ORs that lane's sat flag into the accumulator. When idx==CH−1, go to HOLD; otherwise idx+1.
  - HOLD: out_valid=1 and in_ready=0. out_data and out_sat are stable. When out_ready=1, go to IDLE.
- Arithmetic per lane (a = captured lane value):
  - Sigmoid: d = one − a, computed at WIDTH+1 bits signed.
  - Tanh: d = −a; the product p = a·d is then offset by one.
  - p is the full (2·WIDTH+1)-bit signed product.
  - r = p >>> FRAC (arithmetic shift, floor rounding). For tanh, r = r + one.
  - If r > 2^(WIDTH−1)−1, output 0x7FF…F and flag the lane saturated. If r < −2^(WIDTH−1), output 0x800…0 and flag the lane saturated. Otherwise output r[WIDTH−1:0].
- Result lanes not yet written in the current pass hold their previous values. These are never visible, because out_valid is 0 outside HOLD.
- in_data and in_mode changing while the block is not in IDLE has no effect.

## Timing
- Reset values: state=IDLE, idx=0, out_data=0, out_sat=0, out_valid=0. in_ready is 1 immediately while rst is high.
- Input handshake at edge T. Lanes are computed at edges T+1 … T+CH, and out_valid rises after edge T+CH. Latency is CH+1 edges from accept to an observable output.
- Output handshake at edge U returns the block to IDLE, so in_ready=1 after U. The next accept is at U+1 at the earliest. There is no overlap, so throughput is one vector per CH+2 cycles with no backpressure.
- in_ready is a pure decode of state, with no combinational path from out_ready.
- rst asserted during CALC or HOLD aborts the pass immediately. The vector is dropped, with no partial out_valid.

## Configuration
- DIV_ACT_TANH_EN defined: in_mode selects sigmoid or tanh as described above.
- DIV_ACT_TANH_EN undefined: in_mode is ignored, every lane uses sigmoid, and the tanh offset logic is not built. Port list is unchanged.

## Test plan
All scenarios use WIDTH=32, FRAC=24, CH=4.
- Sigmoid, lanes {0x00800000, 0x01000000, 0x00000000, 0x00400000}, mode 0: out_data lanes {0x00400000, 0x00000000, 0x00000000, 0x00300000}; out_sat=0; out_valid exactly 4 edges after accept.
- Tanh (macro defined), lane 0x00800000, mode 1: out_data lane = 0x00C00000. Lane 0x00000000 gives 0x01000000. With the macro undefined, the same stimulus gives 0x00400000 and 0x00000000.
- Saturation, sigmoid, lane 0 = 0x7FFFFFFF, other lanes 0: lane 0 = 0x80000000, out_sat=1. A following vector of all 0x00800000 gives out_sat=0.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD. out_valid stays 1, out_data is stable, in_ready=0, and in_valid pulses are ignored. Release gives one transfer, then in_ready=1 on the next cycle.
- Back-to-back: in_valid and out_ready held high. Accepts occur every 6 cycles, each result matches its own input vector, and no vector is lost or duplicated.
- Reset mid-CALC: assert rst after 2 CALC edges. out_valid stays 0, out_data=0, in_ready=1. The next vector then completes normally.

Source files
------------

// File: rtl/div_act_array.sv
// Time-multiplexed activation-derivative engine: one shared multiplier walks CH lanes.
// Define DIV_ACT_TANH_EN to build the tanh derivative (1 - a^2) selected by in_mode.
module div_act_array #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24,
    parameter int CH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH*WIDTH-1:0] in_data,
    input  logic                in_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH*WIDTH-1:0] out_data,
    output logic                out_sat
);

    localparam int IDX_W = (CH > 1) ? $clog2(CH) : 1;
    localparam int PW    = 2 * WIDTH + 1;
    localparam logic [IDX_W-1:0]      LAST   = IDX_W'(CH - 1);
    localparam logic signed [WIDTH:0] ONE_D  = (WIDTH + 1)'(1) << FRAC;
    localparam logic signed [PW-1:0]  MAX_P  = {{(PW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [PW-1:0]  MIN_P  = {{(PW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_HOLD
    } state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [CH-1:0][WIDTH-1:0]    act_q, act_d;
    logic [CH-1:0][WIDTH-1:0]    res_q, res_d;
    logic                        sat_q, sat_d;

    logic signed [WIDTH-1:0]     lane_a;
    logic signed [WIDTH:0]       lane_d;
    logic signed [PW-1:0]        prod;
    logic signed [PW-1:0]        shifted;
    logic [WIDTH-1:0]            lane_r;
    logic                        lane_sat;

`ifdef DIV_ACT_TANH_EN
    localparam logic signed [PW-1:0] ONE_P = PW'(1) << FRAC;
    logic mode_q, mode_d;
`else
    logic unused_mode;
    assign unused_mode = in_mode;
`endif

    // Shared lane datapath: the operand is the lane currently addressed by idx_q.
    always_comb begin
        lane_a = act_q[idx_q];
        lane_d = ONE_D - {lane_a[WIDTH-1], lane_a};
`ifdef DIV_ACT_TANH_EN
        if (mode_q) begin
            lane_d = -{lane_a[WIDTH-1], lane_a};
        end
`endif
        prod    = $signed({{(WIDTH + 1){lane_a[WIDTH-1]}}, lane_a})
                * $signed({{WIDTH{lane_d[WIDTH]}}, lane_d});
        shifted = prod >>> FRAC;
`ifdef DIV_ACT_TANH_EN
        if (mode_q) begin
            shifted = shifted + ONE_P;
        end
`endif
        lane_sat = 1'b0;
        lane_r   = shifted[WIDTH-1:0];
        if (shifted > MAX_P) begin
            lane_r   = {1'b0, {(WIDTH - 1){1'b1}}};
            lane_sat = 1'b1;
        end else if (shifted < MIN_P) begin
            lane_r   = {1'b1, {(WIDTH - 1){1'b0}}};
            lane_sat = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        act_d   = act_q;
        res_d   = res_q;
        sat_d   = sat_q;
`ifdef DIV_ACT_TANH_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    act_d   = in_data;
`ifdef DIV_ACT_TANH_EN
                    mode_d  = in_mode;
`endif
                    sat_d   = 1'b0;
                    idx_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                res_d[idx_q] = lane_r;
                sat_d        = sat_q | lane_sat;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            act_q   <= '0;
            res_q   <= '0;
            sat_q   <= 1'b0;
`ifdef DIV_ACT_TANH_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            act_q   <= act_d;
            res_q   <= res_d;
            sat_q   <= sat_d;
`ifdef DIV_ACT_TANH_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign out_data  = res_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_div_act_array.sv
// Self-checking bench for div_act_array: a transaction-level model checked every cycle
// plus literal expectations for the directed vectors.
module tb_div_act_array;

    localparam int W  = 32;
    localparam int F  = 24;
    localparam int CH = 4;
`ifdef DIV_ACT_TANH_EN
    localparam bit TANH = 1'b1;
`else
    localparam bit TANH = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [CH*W-1:0] in_data;
    logic            in_mode;
    logic            out_valid;
    logic            out_ready;
    logic [CH*W-1:0] out_data;
    logic            out_sat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_act_array #(.WIDTH(W), .FRAC(F), .CH(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain 64-bit arithmetic model of one lane.
    function automatic logic [W-1:0] model_lane(input logic [W-1:0] a, input bit mode, output bit sat);
        longint av, one, r, maxv, minv;
        av   = longint'($signed(a));
        one  = longint'(1) << F;
        maxv = (longint'(1) << (W - 1)) - 1;
        minv = -(longint'(1) << (W - 1));
        if (mode && TANH) r = ((-(av * av)) >>> F) + one;
        else              r = (av * (one - av)) >>> F;
        sat = 1'b0;
        if (r > maxv) begin
            sat = 1'b1;
            return {1'b0, {(W - 1){1'b1}}};
        end
        if (r < minv) begin
            sat = 1'b1;
            return {1'b1, {(W - 1){1'b0}}};
        end
        return r[W-1:0];
    endfunction

    bit              busy = 1'b0;
    int              cyc = 0, acc_cyc = 0, n_acc = 0, n_xfer = 0, prev_acc = 0, last_acc = 0;
    logic [CH*W-1:0] exp_vec = '0;
    bit              exp_sat = 1'b0;

    always @(posedge clk or posedge rst) begin
        bit s;
        if (rst) begin
            busy = 1'b0;
        end else begin
            cyc++;
            if (busy) begin
                if ((cyc - 1 - acc_cyc) >= CH && out_ready) begin
                    busy = 1'b0;
                    n_xfer++;
                end
            end else if (in_valid) begin
                busy     = 1'b1;
                acc_cyc  = cyc;
                n_acc++;
                prev_acc = last_acc;
                last_acc = cyc;
                exp_sat  = 1'b0;
                for (int k = 0; k < CH; k++) begin
                    exp_vec[k*W +: W] = model_lane(in_data[k*W +: W], in_mode, s);
                    exp_sat = exp_sat | s;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit ev;
        ev = busy && ((cyc - acc_cyc) >= CH);
        chk("in_ready", in_ready, !busy);
        chk("out_valid", out_valid, ev);
        if (ev) begin
            chk("out_data", out_data, exp_vec);
            chk("out_sat", out_sat, exp_sat);
        end
    end

    task automatic send(input logic [CH*W-1:0] v, input bit m);
        int n;
        @(negedge clk);
        in_data  = v;
        in_mode  = m;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int edges);
        edges = 0;
        while (!out_valid && edges < 50) begin
            @(negedge clk);
            edges++;
        end
        chk("out_timeout", out_valid, 1'b1);
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int              edges, a0, x0;
        logic [CH*W-1:0] held;

        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b0; in_data = '0;
        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_sat", out_sat, 1'b0);
        #21 rst = 1'b0;

        // Sigmoid vector, latency, then backpressure in HOLD.
        send({32'h00400000, 32'h00000000, 32'h01000000, 32'h00800000}, 1'b0);
        wait_out(edges);
        chk("latency", 32'(edges), 32'(CH + 1));
        chk("sig_data", out_data, {32'h00300000, 32'h00000000, 32'h00000000, 32'h00400000});
        chk("sig_sat", out_sat, 1'b0);
        held = out_data;
        a0 = n_acc;
        x0 = n_xfer;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            in_data  = {4{32'h01234567 + 32'(i)}};
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_stable", out_data, held);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_no_accept", 32'(n_acc - a0), 32'd0);
        drain();
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1'b1);
        chk("rel_out_valid", out_valid, 1'b0);
        chk("rel_one_xfer", 32'(n_xfer - x0), 32'd1);

        // Tanh (or sigmoid when tanh is not built).
        send({32'h0, 32'h0, 32'h0, 32'h00800000}, 1'b1);
        wait_out(edges);
        chk("tanh_l0", out_data[31:0], TANH ? 32'h00C00000 : 32'h00400000);
        chk("tanh_l1", out_data[63:32], TANH ? 32'h01000000 : 32'h00000000);
        drain();

        // Saturation then a clean vector.
        send({32'h0, 32'h0, 32'h0, 32'h7FFFFFFF}, 1'b0);
        wait_out(edges);
        chk("sat_l0", out_data[31:0], 32'h80000000);
        chk("sat_flag", out_sat, 1'b1);
        drain();
        send({4{32'h00800000}}, 1'b0);
        wait_out(edges);
        chk("nosat_data", out_data, {4{32'h00400000}});
        chk("nosat_flag", out_sat, 1'b0);
        drain();

        // Back-to-back with in_valid and out_ready held high.
        a0 = n_acc;
        x0 = n_xfer;
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 36; i++) begin
            for (int k = 0; k < CH; k++)
                in_data[k*W +: W] = 32'(i) * 32'h00123457 + 32'(k) * 32'h00200000 - 32'h00800000;
            in_mode = i[0];
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_accepts", 32'(n_acc - a0), 32'd6);
        chk("b2b_xfers", 32'(n_xfer - x0), 32'd6);
        chk("b2b_period", 32'(last_acc - prev_acc), 32'd6);

        // Reset in the middle of a pass.
        send({4{32'h00400000}}, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #2;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_data", out_data, '0);
        chk("mid_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        send({32'h00800000, 32'h0, 32'h01000000, 32'h00400000}, 1'b0);
        wait_out(edges);
        chk("post_rst_latency", 32'(edges), 32'(CH + 1));
        chk("post_rst_data", out_data, {32'h00400000, 32'h0, 32'h0, 32'h00300000});
        drain();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
